// File: rtl/dsp_add_pipe_pkg.sv
// Shared ALU constants for the DSP add path: default operand width, the split
// point between the two pipeline stages, and the signed-overflow rule.
package dsp_add_pipe_pkg;

  // Default full operand/result width.
  localparam int unsigned DSP_ADD_WIDTH = 32;

  // Default width of the low slice added in stage 1.
  localparam int unsigned DSP_ADD_HALF  = 16;

  // Default width of the high slice added in stage 2.
  localparam int unsigned DSP_ADD_HI_W  = DSP_ADD_WIDTH - DSP_ADD_HALF;

  // Two's-complement overflow of an addition, from the operand sign bits and
  // the result sign bit. It is set when both operands have the same sign and
  // the result sign differs from it.
  function automatic logic add_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/dsp_add_stage.sv
// Registered slice adder. When load_i is high it captures a_i + b_i + cin_i
// (one bit wider than the slice); otherwise it holds the previous sum.
module dsp_add_stage
  import dsp_add_pipe_pkg::*;
#(
  parameter int unsigned W = DSP_ADD_HALF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] sum_d;
  logic [W:0] sum_q;

  // Slice add with the carry kept as the extra MSB.
  always_comb begin
    sum_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  end

  // Capture the sum on load; hold it otherwise; clear it on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (load_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o  = sum_q[W-1:0];
  assign cout_o = sum_q[W];

endmodule

// File: rtl/dsp_add_pipe.sv
// Two-stage pipelined adder, computing out = input1 + input2 + carry_in.
// Stage 1 adds the low HALF bits and registers their carry. It also registers
// the upper operand slices. Stage 2 adds the upper slices with that carry and
// drives the outputs. Both sides use a valid/ready handshake. The design has no
// skid buffer, so in_ready depends combinationally on out_ready.
module dsp_add_pipe
  import dsp_add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DSP_ADD_WIDTH,
  parameter int unsigned HALF  = DSP_ADD_HALF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned HI_W = WIDTH - HALF;

  // Pipeline control.
  logic adv1;
  logic adv2;
  logic accept;
  logic load_s2;
  logic s1_v_d, s1_v_q;
  logic s2_v_d, s2_v_q;

  // Stage 1 payload: the low-half sum and carry live in the low adder stage.
  logic [HALF-1:0] s1_lo;
  logic            s1_c;
  logic [HI_W-1:0] s1_a_hi_d, s1_a_hi_q;
  logic [HI_W-1:0] s1_b_hi_d, s1_b_hi_q;

  // Stage 2 payload: the high-half sum and carry live in the high adder stage.
  logic [HI_W-1:0] s2_hi;
  logic            s2_c;
  logic [HALF-1:0] s2_lo_d, s2_lo_q;
  logic            s2_a_msb_d, s2_a_msb_q;
  logic            s2_b_msb_d, s2_b_msb_q;

  // Advance rules, and the next state of each stage valid flag.
  always_comb begin
    adv2    = ~s2_v_q | out_ready;
    adv1    = ~s1_v_q | adv2;
    accept  = in_valid & adv1;
    load_s2 = s1_v_q & adv2;

    s1_v_d = s1_v_q;
    if (adv1) begin
      s1_v_d = accept;
    end

    s2_v_d = s2_v_q;
    if (adv2) begin
      s2_v_d = s1_v_q;
    end
  end

  // Register both valid flags. Reset drops every beat that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  // Next value of the stage 1 upper operand slices: load on accept, hold otherwise.
  always_comb begin
    s1_a_hi_d = s1_a_hi_q;
    s1_b_hi_d = s1_b_hi_q;
    if (accept) begin
      s1_a_hi_d = input1[WIDTH-1:HALF];
      s1_b_hi_d = input2[WIDTH-1:HALF];
    end
  end

  // Register the stage 1 upper operand slices.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a_hi_q <= '0;
      s1_b_hi_q <= '0;
    end else begin
      s1_a_hi_q <= s1_a_hi_d;
      s1_b_hi_q <= s1_b_hi_d;
    end
  end

  // Low slice: sum and carry are captured when a beat is accepted.
  dsp_add_stage #(
    .W (HALF)
  ) u_stage_lo (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .a_i    (input1[HALF-1:0]),
    .b_i    (input2[HALF-1:0]),
    .cin_i  (carry_in),
    .sum_o  (s1_lo),
    .cout_o (s1_c)
  );

  // High slice: adds the registered upper slices and the registered low carry.
  dsp_add_stage #(
    .W (HI_W)
  ) u_stage_hi (
    .clk    (clk),
    .reset  (reset),
    .load_i (load_s2),
    .a_i    (s1_a_hi_q),
    .b_i    (s1_b_hi_q),
    .cin_i  (s1_c),
    .sum_o  (s2_hi),
    .cout_o (s2_c)
  );

  // Next value of the stage 2 low result and operand sign bits. They load
  // together with the high adder stage.
  always_comb begin
    s2_lo_d    = s2_lo_q;
    s2_a_msb_d = s2_a_msb_q;
    s2_b_msb_d = s2_b_msb_q;
    if (load_s2) begin
      s2_lo_d    = s1_lo;
      s2_a_msb_d = s1_a_hi_q[HI_W-1];
      s2_b_msb_d = s1_b_hi_q[HI_W-1];
    end
  end

  // Register the stage 2 low result and operand sign bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_lo_q    <= '0;
      s2_a_msb_q <= 1'b0;
      s2_b_msb_q <= 1'b0;
    end else begin
      s2_lo_q    <= s2_lo_d;
      s2_a_msb_q <= s2_a_msb_d;
      s2_b_msb_q <= s2_b_msb_d;
    end
  end

  // Outputs. overflow is decoded only from stage 2 registers, so it changes
  // on the same edges as out.
  assign in_ready  = adv1;
  assign out_valid = s2_v_q;
  assign out       = {s2_hi, s2_lo_q};
  assign carry_out = s2_c;
  assign overflow  = add_ovf(s2_a_msb_q, s2_b_msb_q, s2_hi[HI_W-1]);

endmodule

// File: tb/tb_dsp_add_pipe.sv
// Directed bench for dsp_add_pipe. Covers reset state, latency, streaming,
// carry and overflow vectors, backpressure, and reset in the middle of a beat.
module tb_dsp_add_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        carry_out;
  logic        overflow;

  int n_checks;
  int n_fail;

  localparam int N = 6;
  logic [31:0] va  [N];
  logic [31:0] vb  [N];
  logic        vc  [N];
  logic [31:0] vs  [N];
  logic        vco [N];
  logic        vov [N];

  dsp_add_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int j;
    n_checks = 0;
    n_fail   = 0;

    // Directed vectors with hand-computed results.
    va[0] = 32'h0000FFFF; vb[0] = 32'h00000001; vc[0] = 1'b0; vs[0] = 32'h00010000; vco[0] = 1'b0; vov[0] = 1'b0;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000000; vc[1] = 1'b1; vs[1] = 32'h00000000; vco[1] = 1'b1; vov[1] = 1'b0;
    va[2] = 32'h7FFFFFFF; vb[2] = 32'h00000001; vc[2] = 1'b0; vs[2] = 32'h80000000; vco[2] = 1'b0; vov[2] = 1'b1;
    va[3] = 32'h80000000; vb[3] = 32'h80000000; vc[3] = 1'b0; vs[3] = 32'h00000000; vco[3] = 1'b1; vov[3] = 1'b1;
    va[4] = 32'h12345678; vb[4] = 32'h9ABCDEF0; vc[4] = 1'b1; vs[4] = 32'hACF13569; vco[4] = 1'b0; vov[4] = 1'b0;
    va[5] = 32'hFFFFFFFF; vb[5] = 32'hFFFFFFFF; vc[5] = 1'b1; vs[5] = 32'hFFFFFFFF; vco[5] = 1'b1; vov[5] = 1'b0;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    input1 = '0; input2 = '0; carry_in = 1'b0;

    // Reset for two cycles, then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out",       out,       0);
    check("rst_carry_out", carry_out, 0);
    check("rst_overflow",  overflow,  0);
    check("rst_in_ready",  in_ready,  1);

    // Single beat: the result must appear two cycles after the accept cycle.
    input1 = va[0]; input2 = vb[0]; carry_in = vc[0]; in_valid = 1'b1;
    #1 check("lat_in_ready", in_ready, 1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    check("lat_cycles", lat, 2);
    check("lat_out", out, vs[0]);
    check("lat_carry_out", carry_out, vco[0]);
    check("lat_overflow", overflow, vov[0]);
    @(negedge clk);
    check("lat_drained", out_valid, 0);

    // Stream all vectors back to back with no backpressure.
    j = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (k < N) begin
        input1 = va[k]; input2 = vb[k]; carry_in = vc[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      if (k < N) check("stream_in_ready", in_ready, 1);
      if (out_valid) begin
        if (j < N) begin
          check($sformatf("stream_out_%0d", j), out, vs[j]);
          check($sformatf("stream_cout_%0d", j), carry_out, vco[j]);
          check($sformatf("stream_ovf_%0d", j), overflow, vov[j]);
        end
        j++;
      end
    end
    check("stream_count", j, N);

    // Backpressure: pairs (1,2), (3,4), (5,6); out_ready low for cycles 2..5.
    @(negedge clk);
    input1 = 32'd1; input2 = 32'd2; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("bp_c0_in_ready", in_ready, 1);
    @(negedge clk);
    input1 = 32'd3; input2 = 32'd4;
    #1 check("bp_c1_in_ready", in_ready, 1);
    @(negedge clk);
    input1 = 32'd5; input2 = 32'd6; out_ready = 1'b0;
    #1;
    check("bp_c2_in_ready", in_ready, 0);
    check("bp_c2_out_valid", out_valid, 1);
    check("bp_c2_out", out, 3);
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp_c%0d_in_ready", c), in_ready, 0);
      check($sformatf("bp_c%0d_out_valid", c), out_valid, 1);
      check($sformatf("bp_c%0d_out", c), out, 3);
    end
    // Release: full pipe accepts and emits in the same edge.
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", in_ready, 1);
    check("bp_rel_out", out, 3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("bp_r1_out_valid", out_valid, 1);
    check("bp_r1_out", out, 7);
    @(negedge clk);
    #1;
    check("bp_r2_out_valid", out_valid, 1);
    check("bp_r2_out", out, 11);
    @(negedge clk);
    #1 check("bp_r3_out_valid", out_valid, 0);

    // Reset in flight: accept (10,20), then reset on the next cycle.
    @(negedge clk);
    input1 = 32'd10; input2 = 32'd20; carry_in = 1'b0; in_valid = 1'b1;
    #1 check("mid_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("mid_out_valid_%0d", c), out_valid, 0);
      check($sformatf("mid_out_%0d", c), out, 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
